// File: rtl/lib_switch_allocator_rr.sv
// Per-output round-robin switch allocator feeding a one-hot crossbar; optional registered outputs via LIB_ALLOC_REG_OUT_EN.
// Latency: 0 cycles (combinational) by default, 1 cycle when LIB_ALLOC_REG_OUT_EN is defined.
// Backpressure: i_en[m]=0 idles output m and leaves its pointer untouched; ce=0 freezes all state.
module lib_switch_allocator_rr #(
  parameter int N = 5,
  parameter int M = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic [N-1:0][M-1:0]     i_req,
  input  logic [M-1:0]            i_en,
  output logic [M-1:0][N-1:0]     o_sel,
  output logic [N-1:0]            o_grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [M-1:0][PW-1:0] ptr;
  logic [N-1:0][M-1:0]  eff_req;
  logic [M-1:0][N-1:0]  sel_c;
  logic [N-1:0]         grant_c;
  logic [M-1:0]         win_vld;
  logic [M-1:0][PW-1:0] win_idx;

  // Malformed multi-hot requests collapse to their lowest-index output.
  always_comb begin
    eff_req = '0;
    for (int j = 0; j < N; j++) begin
      eff_req[j] = i_req[j] & (~i_req[j] + M'(1));
    end
  end

  // Search starts at the pointer and wraps; first requester found wins.
  always_comb begin
    int idx;
    idx     = 0;
    sel_c   = '0;
    win_vld = '0;
    win_idx = '0;
    for (int m = 0; m < M; m++) begin
      if (i_en[m]) begin
        for (int k = 0; k < N; k++) begin
          idx = int'(ptr[m]) + k;
          if (idx >= N) idx = idx - N;
          if (!win_vld[m] && eff_req[idx][m]) begin
            win_vld[m]      = 1'b1;
            win_idx[m]      = PW'(idx);
            sel_c[m][idx]   = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    grant_c = '0;
    for (int m = 0; m < M; m++) begin
      grant_c = grant_c | sel_c[m];
    end
  end

  // The winner moves to lowest priority on its output; idle outputs keep their pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (ce) begin
      for (int m = 0; m < M; m++) begin
        if (win_vld[m]) begin
          ptr[m] <= (win_idx[m] == PW'(N - 1)) ? '0 : win_idx[m] + PW'(1);
        end
      end
    end
  end

`ifdef LIB_ALLOC_REG_OUT_EN
  logic [M-1:0][N-1:0] sel_q;
  logic [N-1:0]        grant_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q   <= '0;
      grant_q <= '0;
    end else if (ce) begin
      sel_q   <= sel_c;
      grant_q <= grant_c;
    end
  end

  assign o_sel   = sel_q;
  assign o_grant = grant_q;
`else
  assign o_sel   = sel_c;
  assign o_grant = grant_c;
`endif

endmodule

// File: tb/tb_lib_switch_allocator_rr.sv
// Self-checking bench for lib_switch_allocator_rr: directed scenarios plus random traffic against a round-robin model.
module tb_lib_switch_allocator_rr;
  localparam int N = 5;
  localparam int M = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic                ce;
  logic [N-1:0][M-1:0] i_req;
  logic [M-1:0]        i_en;
  logic [M-1:0][N-1:0] o_sel;
  logic [N-1:0]        o_grant;

  lib_switch_allocator_rr #(.N(N), .M(M)) dut (
    .clk(clk), .reset(reset), .ce(ce), .i_req(i_req), .i_en(i_en),
    .o_sel(o_sel), .o_grant(o_grant)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int mptr[M];
  logic [M-1:0][N-1:0] m_sel, q_sel;
  logic [N-1:0]        m_grant, q_grant;

  function automatic int lowest(input logic [M-1:0] row);
    for (int m = 0; m < M; m++) if (row[m]) return m;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: each enabled output scans inputs circularly from its pointer.
  task automatic model();
    bit done;
    int j;
    m_sel   = '0;
    m_grant = '0;
    for (int m = 0; m < M; m++) begin
      done = 0;
      if (i_en[m]) begin
        for (int k = 0; k < N; k++) begin
          j = (mptr[m] + k) % N;
          if (!done && lowest(i_req[j]) == m) begin
            m_sel[m][j] = 1'b1;
            m_grant[j]  = 1'b1;
            done = 1;
          end
        end
      end
    end
  endtask

  task automatic drive(input logic [N-1:0][M-1:0] req, input logic [M-1:0] en,
                       input logic c, input logic r);
    @(negedge clk);
    i_req = req; i_en = en; ce = c; reset = r;
    #1;
    model();
`ifdef LIB_ALLOC_REG_OUT_EN
    chk("o_sel", 32'(o_sel), 32'(q_sel));
    chk("o_grant", 32'(o_grant), 32'(q_grant));
`else
    chk("o_sel", 32'(o_sel), 32'(m_sel));
    chk("o_grant", 32'(o_grant), 32'(m_grant));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int m = 0; m < M; m++) mptr[m] = 0;
      q_sel = '0; q_grant = '0;
    end else if (ce) begin
      q_sel = m_sel; q_grant = m_grant;
      for (int m = 0; m < M; m++)
        for (int j = 0; j < N; j++)
          if (m_sel[m][j]) mptr[m] = (j + 1) % N;
    end
  endtask

  task automatic step(input logic [N-1:0][M-1:0] req, input logic [M-1:0] en,
                      input logic c, input logic r);
    drive(req, en, c, r);
    tick();
  endtask

  logic [N-1:0][M-1:0] rq;
  logic [M-1:0] row;
  logic [N-1:0] gcnt;

  initial begin
    reset = 1'b1; ce = 1'b1; i_req = '0; i_en = '1;
    for (int m = 0; m < M; m++) mptr[m] = 0;
    q_sel = '0; q_grant = '0;
    repeat (2) @(posedge clk);

    // Reset state, then idle
    step('0, '1, 1'b1, 1'b1);
    chk("reset_sel", 32'(o_sel), 32'd0);
    step('0, '1, 1'b1, 1'b0);

    // Contention: inputs 0,2,4 on output 1
    rq = '0; rq[0] = 5'b00010; rq[2] = 5'b00010; rq[4] = 5'b00010;
    gcnt = '0;
    for (int c = 0; c < 4; c++) begin
      drive(rq, '1, 1'b1, 1'b0);
`ifndef LIB_ALLOC_REG_OUT_EN
      case (c)
        0: chk("cont_sel1_c0", 32'(o_sel[1]), 32'b00001);
        1: chk("cont_sel1_c1", 32'(o_sel[1]), 32'b00100);
        2: chk("cont_sel1_c2", 32'(o_sel[1]), 32'b10000);
        default: chk("cont_sel1_c3", 32'(o_sel[1]), 32'b00001);
      endcase
      if (c < 3) gcnt = gcnt | o_grant;
`endif
      tick();
    end
`ifndef LIB_ALLOC_REG_OUT_EN
    chk("cont_each_once", 32'(gcnt), 32'b10101);
`endif

    // Wrap: push ptr[3] to 4, then inputs 4 and 0 compete
    rq = '0; rq[3] = 5'b01000;
    step(rq, '1, 1'b1, 1'b0);
    rq = '0; rq[4] = 5'b01000; rq[0] = 5'b01000;
    drive(rq, '1, 1'b1, 1'b0);
`ifndef LIB_ALLOC_REG_OUT_EN
    chk("wrap_in4", 32'(o_sel[3]), 32'b10000);
`endif
    tick();
    drive(rq, '1, 1'b1, 1'b0);
`ifndef LIB_ALLOC_REG_OUT_EN
    chk("wrap_in0", 32'(o_sel[3]), 32'b00001);
`endif
    tick();

    // Backpressure on output 2
    rq = '0; rq[1] = 5'b00100;
    for (int c = 0; c < 2; c++) begin
      drive(rq, 5'b11011, 1'b1, 1'b0);
      chk("bp_sel2_idle", 32'(o_sel[2]), 32'd0);
      chk("bp_grant1_idle", 32'(o_grant[1]), 32'd0);
      tick();
    end
    drive(rq, '1, 1'b1, 1'b0);
`ifndef LIB_ALLOC_REG_OUT_EN
    chk("bp_release", 32'(o_grant), 32'b00010);
`endif
    tick();
    step('0, '1, 1'b1, 1'b0);

    // Parallel + malformed request
    rq = '0; rq[0] = 5'b00001; rq[1] = 5'b10000; rq[3] = 5'b00110;
    drive(rq, '1, 1'b1, 1'b0);
`ifndef LIB_ALLOC_REG_OUT_EN
    chk("par_grant", 32'(o_grant), 32'b01011);
    chk("par_sel1", 32'(o_sel[1]), 32'b01000);
    chk("par_sel2", 32'(o_sel[2]), 32'd0);
`endif
    tick();

    // ce gating under contention
    rq = '0; rq[0] = 5'b00010; rq[2] = 5'b00010; rq[4] = 5'b00010;
    repeat (3) step(rq, '1, 1'b0, 1'b0);
    step(rq, '1, 1'b1, 1'b0);

    // Mid-stream reset after ptr[1]=3
    rq = '0; rq[2] = 5'b00010;
    step(rq, '1, 1'b1, 1'b0);
    step(rq, '1, 1'b1, 1'b1);
    rq = '0; rq[0] = 5'b00010; rq[2] = 5'b00010;
    drive(rq, '1, 1'b1, 1'b0);
`ifndef LIB_ALLOC_REG_OUT_EN
    chk("post_reset_in0", 32'(o_sel[1]), 32'b00001);
`endif
    tick();

    // Random traffic
    for (int c = 0; c < 500; c++) begin
      for (int j = 0; j < N; j++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 3) row = '0;
        else if (r < 9) row = M'(1) << $urandom_range(0, M - 1);
        else row = M'($urandom);
        rq[j] = row;
      end
      step(rq, M'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
